clock_display_spi: RTL
======================

Name: clock_display_spi

Overview:
- Reads the time outputs of the clock core (hours/minutes/seconds plus the update strobe) and writes them to a MAX7219-style 8-digit LED driver over a 3-wire SPI link.
- Converts the binary fields to BCD and transmits 16-bit frames.
- Runs a one-time driver initialisation sequence after reset.
- Sits between the clock core and the top-level display pins.

Parameters:
- SCLK_DIV, 4: i_clk cycles per SCLK half-period; legal range ≥1.
- INTENSITY, 4'h8: value written to the driver intensity register (0x0A).

Ports:
- i_clk  input  1  system clock (~50 MHz)
- i_reset_n  input  1  reset; one clock, asynchronous, active-low
- i_clk_stb  input  1  time-updated strobe, one cycle wide
- i_seconds  input  6  binary seconds, 0–59
- i_minutes  input  6  binary minutes, 0–59
- i_hours  input  5  binary hours, 0–23
- o_sclk  output  1  SPI clock, idles low
- o_mosi  output  1  SPI data, MSB first
- o_cs_n  output  1  SPI chip select / LOAD, active low
- o_busy  output  1  high while any frame sequence is in progress or pending

Behaviour:
- Reset values: o_sclk=0, o_mosi=0, o_cs_n=1, o_busy=0, pending=0. FSM state is INIT_START.
- FSM states: INIT_START, LOAD, SHIFT, GAP, NEXT, IDLE.
- After reset release, o_busy=1 on the first clock edge. The INIT sequence then runs, followed immediately by one UPDATE using the current inputs.
- INIT frames, in order:
  - 0x0F00 (test off)
  - 0x0B05 (scan limit 6 digits)
  - 0x093F (code-B on digits 0–5)
  - 0x0A0{INTENSITY}
  - 0x0C01 (normal operation)
- UPDATE frames:
  - Registers are latched 1 cycle after the strobe. BCD is derived combinationally from the latched values: tens = v/10, ones = v%10.
  - Frame order:
    - 0x01,sec_ones
    - 0x02,sec_tens
    - 0x03,{DP=1,min_ones}
    - 0x04,min_tens
    - 0x05,{DP=1,hr_ones}
    - 0x06,hr_tens_or_blank
  - Data byte = {dp,3'b000,nibble}.
  - hr_tens_or_blank = 0xF (code-B blank) when hours < 10.
  - Out-of-range inputs are converted arithmetically with no clamping: seconds=63 gives tens 6, ones 3; hours=31 gives tens 3, ones 1.
- Frame timing (SPI mode 0):
  - o_cs_n falls with o_mosi = bit15 and o_sclk = 0.
  - Each bit: o_sclk low for SCLK_DIV cycles, then high for SCLK_DIV cycles.
  - o_mosi changes only on the cycle o_sclk goes low, or when o_cs_n falls.
  - o_cs_n stays low exactly 32*SCLK_DIV cycles.
  - o_cs_n then rises with o_sclk = 0 and stays high ≥2*SCLK_DIV cycles (GAP) before the next frame.
  - o_mosi returns to 0 when o_cs_n rises.
- Latency: a strobe sampled in IDLE at cycle T latches inputs at T+1. o_cs_n falls at T+2. o_busy=1 from T+1.
- Strobe while busy (INIT, UPDATE or GAP) sets pending. Inputs are not latched mid-sequence.
- When the last frame's GAP completes:
  - If pending: clear it, latch the current inputs, and start a new UPDATE. o_busy stays 1.
  - Otherwise enter IDLE and drop o_busy.
- Multiple strobes during one sequence collapse into a single pending update.
- A strobe in the same cycle a sequence finishes counts as pending, so the update is never lost.
- Asynchronous reset mid-frame: all outputs return to reset values immediately, which aborts the frame (o_cs_n=1). INIT is then rerun from frame 0.
- Bit counter 4 bits and frame index 4 bits, both wrapping with no overflow. The SCLK_DIV counter is sized by $clog2(SCLK_DIV)+1.

Test Plan:
- Reset then run with SCLK_DIV=2, inputs 12:34:56:
  - The SPI monitor decodes 0x0F00, 0x0B05, 0x093F, 0x0A08, 0x0C01, 0x0106, 0x0205, 0x0384, 0x0403, 0x0582, 0x0601.
  - Each o_cs_n low window is 64 cycles.
  - o_busy then falls.
- Idle, inputs 07:00:09, single strobe:
  - o_cs_n falls 2 cycles later.
  - Frames: 0x0109, 0x0200, 0x0380, 0x0400, 0x0587, 0x060F (blank hours tens).
- Three strobes during one update, with inputs changing to 23:59:59 before the last GAP ends:
  - Exactly one extra update follows: 0x0109, 0x0205, 0x0389, 0x0405, 0x0583, 0x0602.
  - Then IDLE.
- Strobe coincident with the final GAP-end cycle: a second update is sent and o_busy never drops between the two.
- Reset asserted mid-bit of frame 3:
  - o_cs_n=1, o_sclk=0 and o_busy=0 in the same cycle.
  - After release, the sequence restarts at 0x0F00.
- Out-of-range inputs 31:63:63 with SCLK_DIV=1:
  - Frames 0x0103, 0x0206, 0x0383, 0x0406, 0x0581, 0x0603.
  - o_sclk half-period is 1 cycle.

Source files
------------

// File: rtl/clock_display_spi.sv
// Streams the clock core's time to a MAX7219-style 8-digit LED driver over 3-wire SPI.
// A one-time driver initialisation runs after reset; afterwards each time strobe sends six BCD digit frames.
module clock_display_spi #(
  parameter int         SCLK_DIV  = 4,
  parameter logic [3:0] INTENSITY = 4'h8
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_clk_stb,
  input  logic [5:0] i_seconds,
  input  logic [5:0] i_minutes,
  input  logic [4:0] i_hours,
  output logic       o_sclk,
  output logic       o_mosi,
  output logic       o_cs_n,
  output logic       o_busy
);

  typedef enum logic [2:0] {INIT_START, LOAD, SHIFT, GAP, NEXT, IDLE} state_t;

  localparam int            CW        = $clog2(SCLK_DIV) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(SCLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(2 * SCLK_DIV - 1);

  state_t        state;
  logic [CW-1:0] div_cnt;
  logic [3:0]    bit_idx;
  logic [3:0]    frame_idx;
  logic          init_mode;
  logic          pending;

  logic [5:0]    sec_r;
  logic [5:0]    min_r;
  logic [4:0]    hr_r;

  logic [15:0]   frame;
  logic          last_frame;
  logic          latch;

  function automatic logic [3:0] tens(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  function automatic logic [3:0] ones(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

  assign last_frame = init_mode ? (frame_idx == 4'd4) : (frame_idx == 4'd5);

  // Inputs are sampled only when a new update sequence begins, never mid-sequence.
  assign latch = ((state == IDLE) && i_clk_stb) ||
                 ((state == NEXT) && last_frame && (init_mode || pending || i_clk_stb));

  always_ff @(posedge i_clk) begin
    if (latch) begin
      sec_r <= i_seconds;
      min_r <= i_minutes;
      hr_r  <= i_hours;
    end
  end

  always_comb begin
    frame = 16'h0000;
    if (init_mode) begin
      case (frame_idx)
        4'd0:    frame = 16'h0F00;
        4'd1:    frame = 16'h0B05;
        4'd2:    frame = 16'h093F;
        4'd3:    frame = {8'h0A, 4'h0, INTENSITY};
        4'd4:    frame = 16'h0C01;
        default: frame = 16'h0000;
      endcase
    end else begin
      case (frame_idx)
        4'd0:    frame = {8'h01, 4'h0, ones(sec_r)};
        4'd1:    frame = {8'h02, 4'h0, tens(sec_r)};
        4'd2:    frame = {8'h03, 4'h8, ones(min_r)};
        4'd3:    frame = {8'h04, 4'h0, tens(min_r)};
        4'd4:    frame = {8'h05, 4'h8, ones({1'b0, hr_r})};
        4'd5:    frame = {8'h06, 4'h0, (hr_r < 5'd10) ? 4'hF : tens({1'b0, hr_r})};
        default: frame = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= INIT_START;
      o_sclk    <= 1'b0;
      o_mosi    <= 1'b0;
      o_cs_n    <= 1'b1;
      o_busy    <= 1'b0;
      pending   <= 1'b0;
      init_mode <= 1'b1;
      frame_idx <= 4'd0;
      bit_idx   <= 4'd0;
      div_cnt   <= '0;
    end else begin
      if (i_clk_stb && (state != IDLE))
        pending <= 1'b1;
      case (state)
        INIT_START: begin
          o_busy    <= 1'b1;
          init_mode <= 1'b1;
          frame_idx <= 4'd0;
          state     <= LOAD;
        end
        LOAD: begin
          o_cs_n  <= 1'b0;
          o_sclk  <= 1'b0;
          o_mosi  <= frame[15];
          bit_idx <= 4'd15;
          div_cnt <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (div_cnt == HALF_LAST) begin
            div_cnt <= '0;
            if (!o_sclk) begin
              o_sclk <= 1'b1;
            end else begin
              o_sclk <= 1'b0;
              if (bit_idx == 4'd0) begin
                o_cs_n <= 1'b1;
                o_mosi <= 1'b0;
                state  <= GAP;
              end else begin
                bit_idx <= bit_idx - 4'd1;
                o_mosi  <= frame[bit_idx - 4'd1];
              end
            end
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end
        GAP: begin
          if (div_cnt == GAP_LAST)
            state <= NEXT;
          else
            div_cnt <= div_cnt + CW'(1);
        end
        NEXT: begin
          // A strobe arriving on this very cycle is folded in with pending so it is never dropped.
          if (last_frame) begin
            if (init_mode || pending || i_clk_stb) begin
              init_mode <= 1'b0;
              pending   <= 1'b0;
              frame_idx <= 4'd0;
              state     <= LOAD;
            end else begin
              o_busy <= 1'b0;
              state  <= IDLE;
            end
          end else begin
            frame_idx <= frame_idx + 4'd1;
            state     <= LOAD;
          end
        end
        IDLE: begin
          if (i_clk_stb) begin
            o_busy    <= 1'b1;
            init_mode <= 1'b0;
            frame_idx <= 4'd0;
            state     <= LOAD;
          end
        end
        default: state <= INIT_START;
      endcase
    end
  end

endmodule
